fei4_rx_arbiter: RTL
====================

// Module: fei4_rx_arbiter
// PURPOSE
//  Round-robin read arbiter merging N_CH fei4_rx_core FIFO outputs into one 32-bit FWFT word stream.
//  Grants one channel at a time and drains up to MAX_BURST words per grant.
//  Sits between the per-channel RX FIFOs and the common SRAM/USB readout FIFO.
//  FEI4 words keep their header byte, so the arbiter does not retag data.
// PARAMETERS
//  N_CH       4   number of RX channels (1..16)
//  MAX_BURST  16  max words popped per grant (1..256)
//  DW         32  word width
// PORTS
//  BUS_CLK        in   1         single clock; all RX FIFO read sides and the output run on it
//  BUS_RST_N      in   1         asynchronous reset, active-low
//  CH_EN          in   N_CH      per-channel enable mask; 0 = never granted
//  FIFO_EMPTY     in   N_CH      per-channel FWFT empty flags
//  FIFO_DATA      in   N_CH*DW   per-channel FWFT data; channel i uses [i*DW +: DW]
//  FIFO_READ      out  N_CH      per-channel pop strobes; combinational, at most one bit set
//  OUT_READ       in   1         pop from the merged output
//  OUT_EMPTY      out  1         merged output holds no valid word
//  OUT_DATA       out  DW        merged output word; valid while !OUT_EMPTY
//  GRANT_ID       out  clog2     channel currently granted; holds last grant when idle
//  BUSY           out  1         high in GRANT state
// BEHAVIOUR
//  Reset values: OUT_EMPTY=1, OUT_DATA=0, GRANT_ID=0, BUSY=0, FIFO_READ=0, state=IDLE, rr pointer=0.
//  Output stage: one registered word, out_vld. out_ready = !out_vld | OUT_READ.
//  FSM IDLE: req = CH_EN & ~FIFO_EMPTY.
//   - If req!=0, pick the first requester at or after ptr, wrapping modulo N_CH.
//   - Load GRANT_ID, clear burst_cnt, go to GRANT. No pop in IDLE, so a grant costs 1 cycle.
//  FSM GRANT, channel g:
//   - pop = CH_EN[g] & !FIFO_EMPTY[g] & out_ready.
//   - FIFO_READ[g] = pop in the same cycle.
//   - On pop, OUT_DATA <= FIFO_DATA[g] and out_vld <= 1, so the word is visible the next cycle.
//   - Sustains 1 word/cycle when OUT_READ stays high.
//  Release to IDLE with ptr <= (g+1) mod N_CH when any of these holds:
//   - pop and burst_cnt==MAX_BURST-1;
//   - FIFO_EMPTY[g] is high;
//   - CH_EN[g] is low. In this case no pop occurs in that cycle.
//  Output backpressure (!out_ready) holds the grant; it does not count toward the burst and does not release.
//  out_vld update: cleared on OUT_READ without pop; set on pop. A simultaneous pop and OUT_READ replaces the word.
//  OUT_READ while OUT_EMPTY is ignored; no underflow.
//  N_CH=1: the pointer always stays 0, and IDLE still occurs between bursts.
//  Burst counter is 8 bit; it compares against MAX_BURST-1 and never wraps within a grant.
//  Async reset mid-burst: FIFO_READ drops immediately and the held output word is discarded.
// CONFIGURATION
//  FEI4_RX_ARB_CNT_EN defined:
//   - Adds output WORD_CNT [31:0], reset 0.
//   - Increments on every pop and saturates at 0xFFFFFFFF.
//   - Adds input CNT_CLR (synchronous, 1 cycle). CNT_CLR has priority over the increment.
//  Not defined: the WORD_CNT and CNT_CLR ports and their logic are absent; the core behaviour is identical.
// STRUCTURE
//  Include file fei4_rx_arb_defs.vh:
//   - FSM state localparams ST_IDLE/ST_GRANT;
//   - clog2 function;
//   - default DW.
//  Sub-module fei4_rx_rr_pick (combinational):
//   - inputs req[N_CH] and ptr;
//   - outputs found and idx, the first set bit at or after ptr, wrapping.
//  Top module: FSM, burst counter, output register, optional counter.
// TESTING
//  1. Only ch2 has 5 words, OUT_READ=1:
//     -> 1 idle cycle, then FIFO_READ[2] for 5 consecutive cycles;
//     -> OUT_DATA follows in order 1 cycle later;
//     -> GRANT_ID=2, then IDLE with ptr=3.
//  2. All 4 channels hold 40 words, MAX_BURST=16:
//     -> grant order 0,1,2,3,0,... with 16 words per grant;
//     -> channel words are never interleaved within a burst.
//  3. OUT_READ=0 for 10 cycles mid-burst:
//     -> exactly 1 word is held and FIFO_READ=0 during the stall;
//     -> on resume there is no loss or duplicate and burst_cnt is unchanged.
//  4. CH_EN[1] dropped while ch1 is granted with 8 words left:
//     -> no further FIFO_READ[1];
//     -> the next grant goes to ch2.
//  5. BUS_RST_N pulsed low mid-burst:
//     -> OUT_EMPTY=1 and FIFO_READ=0 asynchronously;
//     -> after release the first grant goes to the lowest requesting channel from ptr 0.
//  6. With FEI4_RX_ARB_CNT_EN, 100 words popped, then a CNT_CLR pulse coincident with a pop:
//     -> WORD_CNT=100, then WORD_CNT=0.

Source files
------------

// File: rtl/fei4_rx_arbiter_pkg.sv
// Shared types and helpers for the FEI4 RX read arbiter.
// FSM state encoding, index-width helper, default data width.
package fei4_rx_arbiter_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // ceil(log2(n)), never below 1 so N_CH=1 still has a GRANT_ID bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fei4_rx_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
// Ports: req, ptr in; found, idx out. Purely combinational.
module fei4_rx_rr_pick #(
  parameter int N_CH = 4,
  parameter int GW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            found,
  output logic [GW-1:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && req[(int'(ptr) + k) % N_CH]) begin
        found = 1'b1;
        idx   = GW'((int'(ptr) + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/fei4_rx_arbiter.sv
// Round-robin merge of N_CH FWFT RX FIFOs into one FWFT word stream.
// Ports: BUS_CLK/BUS_RST_N, CH_EN, FIFO_EMPTY/DATA/READ, OUT_READ,
// OUT_EMPTY, OUT_DATA, GRANT_ID, BUSY. FEI4_RX_ARB_CNT_EN adds
// CNT_CLR in and a saturating WORD_CNT out.
module fei4_rx_arbiter
  import fei4_rx_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 16,
  parameter int DW        = DW_DEF,
  localparam int GW       = clog2(N_CH)
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST_N,
  input  logic [N_CH-1:0]  CH_EN,
  input  logic [N_CH-1:0]  FIFO_EMPTY,
  input  logic [N_CH*DW-1:0] FIFO_DATA,
  output logic [N_CH-1:0]  FIFO_READ,
  input  logic             OUT_READ,
  output logic             OUT_EMPTY,
  output logic [DW-1:0]    OUT_DATA,
  output logic [GW-1:0]    GRANT_ID,
`ifdef FEI4_RX_ARB_CNT_EN
  input  logic             CNT_CLR,
  output logic [31:0]      WORD_CNT,
`endif
  output logic             BUSY
);

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   gnt_nxt;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic [7:0]      bcnt_q, bcnt_d;
  logic            out_vld_q;
  logic [DW-1:0]   out_data_q;
  logic [N_CH-1:0] req;
  logic            g_en, g_emp;
  logic            out_ready;
  logic            last;
  logic            pop;

  assign req       = CH_EN & ~FIFO_EMPTY;
  assign g_en      = CH_EN[gnt_q];
  assign g_emp     = FIFO_EMPTY[gnt_q];
  assign out_ready = ~out_vld_q | OUT_READ;
  assign last      = (bcnt_q == 8'(MAX_BURST - 1));
  assign gnt_nxt   = (gnt_q == GW'(N_CH - 1))
                   ? '0 : gnt_q + GW'(1);

  fei4_rx_rr_pick #(
    .N_CH (N_CH),
    .GW   (GW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    bcnt_d    = bcnt_q;
    pop       = 1'b0;
    FIFO_READ = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          bcnt_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        pop = g_en & ~g_emp & out_ready;
        if (pop) begin
          FIFO_READ[gnt_q] = 1'b1;
          bcnt_d = bcnt_q + 8'd1;
        end
        // stall (!out_ready) keeps the grant
        if ((pop & last) | g_emp | ~g_en) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      bcnt_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      bcnt_q  <= bcnt_d;
      if (pop) begin
        out_vld_q  <= 1'b1;
        out_data_q <= FIFO_DATA[gnt_q*DW +: DW];
      end else if (OUT_READ) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign OUT_EMPTY = ~out_vld_q;
  assign OUT_DATA  = out_data_q;
  assign GRANT_ID  = gnt_q;
  assign BUSY      = (state_q == ST_GRANT);

`ifdef FEI4_RX_ARB_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      cnt_q <= '0;
    end else if (CNT_CLR) begin
      cnt_q <= '0;
    end else if (pop && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign WORD_CNT = cnt_q;
`endif

endmodule
